// File: rtl/interrupt_controller_pkg.sv
// Shared types and helpers for the 8259A-style interrupt controller blocks.
// Contents: acknowledge-sequence state enum, captured-config struct, default
//   CALL opcode, and the vector byte builder used by the INTA# driver.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PULSE1 = 3'd1,
    WAIT2  = 3'd2,
    PULSE2 = 3'd3,
    WAIT3  = 3'd4,
    PULSE3 = 3'd5
  } ack_state_t;

  // Configuration frozen at the first INTA# fall of a sequence.
  typedef struct packed {
    logic       mode;   // 1 = 8086, 0 = 8080
    logic       adi;    // 1 = interval 4, 0 = interval 8
    logic [2:0] a7_5;
    logic [7:0] icw2;
    logic       dve;    // 0 = a cascaded slave supplies vector bytes
  } ack_cfg_t;

  localparam logic [7:0] CALL_OPCODE_DEFAULT = 8'hCD;

  // pulse is 1..3; any pulse that carries no byte returns 8'h00.
  function automatic logic [7:0] build_vector(input logic       mode,
                                              input logic       adi,
                                              input logic [2:0] a7_5,
                                              input logic [7:0] icw2,
                                              input logic [2:0] level,
                                              input logic [1:0] pulse);
    logic [7:0] v;
    v = 8'h00;
    if (mode) begin
      if (pulse == 2'd2) v = {icw2[7:3], level};
    end else begin
      case (pulse)
        2'd1:    v = CALL_OPCODE_DEFAULT;
        2'd2:    v = adi ? {a7_5, level, 2'b00} : {a7_5[2:1], level, 3'b000};
        2'd3:    v = icw2;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/inta_edge_detector.sv
// INTA# edge detector with suppression of a false edge right after reset.
// Ports: clock, reset_n, interrupt_acknowledge_n in; fall, rise (combinational,
//   valid in the cycle the edge is sampled) out.
module inta_edge_detector (
  input  logic clock,
  input  logic reset_n,
  input  logic interrupt_acknowledge_n,
  output logic fall,
  output logic rise
);

  logic inta_d;
  logic armed;  // low only during the first cycle after reset release

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inta_d <= 1'b1;
      armed  <= 1'b0;
    end else begin
      inta_d <= interrupt_acknowledge_n;
      armed  <= 1'b1;
    end
  end

  // In the first cycle out of reset inta_d is just loaded, not compared, so an
  // INTA# already low at release is not mistaken for a fall.
  assign fall = armed &  inta_d & ~interrupt_acknowledge_n;
  assign rise = armed & ~inta_d &  interrupt_acknowledge_n;

endmodule

// File: rtl/interrupt_acknowledge_vector_driver.sv
// Drives the vector bytes onto the data bus during 8080 (3-pulse) or 8086
//   (2-pulse) INTA# sequences, and tells the in-service logic when to latch.
// Ports: clock/reset_n, INTA#, ICW config, resolver level, cascade enable in;
//   latch_in_service, data_bus_out(+enable), end_of_acknowledge_sequence out.
module interrupt_acknowledge_vector_driver
  import interrupt_controller_pkg::*;
#(
  parameter logic [7:0] CALL_OPCODE = CALL_OPCODE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       interrupt_acknowledge_n,
  input  logic       initialization_write,
  input  logic       u8086_or_mcs80_config,
  input  logic       call_address_interval_4_or_8_config,
  input  logic [2:0] interrupt_vector_address,
  input  logic [7:0] interrupt_vector_address_high,
  input  logic [2:0] acknowledge_level,
  input  logic       drive_vector_enable,
  output logic       latch_in_service,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable,
  output logic       end_of_acknowledge_sequence
);

  logic fall;
  logic rise;

  inta_edge_detector u_edge (
    .clock                  (clock),
    .reset_n                (reset_n),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .fall                   (fall),
    .rise                   (rise)
  );

  ack_state_t state, state_n;
  ack_cfg_t   cfg_q, cfg_n;
  logic [2:0] level_q, level_n;
  logic       latch_n, end_n, en_n;
  logic [1:0] pulse_n;
  logic [7:0] byte_n, dat_n;

  always_comb begin
    state_n = state;
    cfg_n   = cfg_q;
    level_n = level_q;
    latch_n = 1'b0;
    end_n   = 1'b0;
    if (initialization_write) begin
      state_n = IDLE;  // abort wins over any edge this cycle, no end pulse
    end else begin
      case (state)
        IDLE: if (fall) begin
          state_n = PULSE1;
          latch_n = 1'b1;
          level_n = acknowledge_level;
          cfg_n   = '{mode: u8086_or_mcs80_config,
                      adi:  call_address_interval_4_or_8_config,
                      a7_5: interrupt_vector_address,
                      icw2: interrupt_vector_address_high,
                      dve:  drive_vector_enable};
        end
        PULSE1: if (rise) state_n = WAIT2;
        WAIT2:  if (fall) state_n = PULSE2;
        PULSE2: if (rise) begin
          if (cfg_q.mode) begin
            state_n = IDLE;
            end_n   = 1'b1;
          end else begin
            state_n = WAIT3;
          end
        end
        WAIT3:  if (fall) state_n = PULSE3;
        PULSE3: if (rise) begin
          state_n = IDLE;
          end_n   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end

    case (state_n)
      PULSE1:  pulse_n = 2'd1;
      PULSE2:  pulse_n = 2'd2;
      PULSE3:  pulse_n = 2'd3;
      default: pulse_n = 2'd0;
    endcase

    // 8086 pulse 1 carries nothing; the 8080 CALL byte is always ours to
    // drive, every other byte only when no slave owns the vector.
    en_n = (pulse_n != 2'd0) && !(cfg_n.mode && pulse_n == 2'd1) &&
           (cfg_n.dve || (!cfg_n.mode && pulse_n == 2'd1));
    byte_n = (!cfg_n.mode && pulse_n == 2'd1) ? CALL_OPCODE :
             build_vector(cfg_n.mode, cfg_n.adi, cfg_n.a7_5, cfg_n.icw2,
                          level_n, pulse_n);
    dat_n = en_n ? byte_n : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                       <= IDLE;
      cfg_q                       <= '0;
      level_q                     <= 3'd0;
      latch_in_service            <= 1'b0;
      data_bus_out                <= 8'h00;
      data_bus_out_enable         <= 1'b0;
      end_of_acknowledge_sequence <= 1'b0;
    end else begin
      state                       <= state_n;
      cfg_q                       <= cfg_n;
      level_q                     <= level_n;
      latch_in_service            <= latch_n;
      data_bus_out                <= dat_n;
      data_bus_out_enable         <= en_n;
      end_of_acknowledge_sequence <= end_n;
    end
  end

endmodule

// File: tb/tb_interrupt_acknowledge_vector_driver.sv
// Bench for interrupt_acknowledge_vector_driver: table of full INTA# sequences
//   with hand-computed bytes, plus abort and reset corner sequences.
// Ports: none.
module tb_interrupt_acknowledge_vector_driver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       interrupt_acknowledge_n;
  logic       initialization_write;
  logic       u8086_or_mcs80_config;
  logic       call_address_interval_4_or_8_config;
  logic [2:0] interrupt_vector_address;
  logic [7:0] interrupt_vector_address_high;
  logic [2:0] acknowledge_level;
  logic       drive_vector_enable;
  logic       latch_in_service;
  logic [7:0] data_bus_out;
  logic       data_bus_out_enable;
  logic       end_of_acknowledge_sequence;

  int checks = 0;
  int failures = 0;

  interrupt_acknowledge_vector_driver dut (
    .clock                              (clock),
    .reset_n                            (reset_n),
    .interrupt_acknowledge_n            (interrupt_acknowledge_n),
    .initialization_write               (initialization_write),
    .u8086_or_mcs80_config              (u8086_or_mcs80_config),
    .call_address_interval_4_or_8_config(call_address_interval_4_or_8_config),
    .interrupt_vector_address           (interrupt_vector_address),
    .interrupt_vector_address_high      (interrupt_vector_address_high),
    .acknowledge_level                  (acknowledge_level),
    .drive_vector_enable                (drive_vector_enable),
    .latch_in_service                   (latch_in_service),
    .data_bus_out                       (data_bus_out),
    .data_bus_out_enable                (data_bus_out_enable),
    .end_of_acknowledge_sequence        (end_of_acknowledge_sequence)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        mode;
    logic        adi;
    logic [2:0]  a7_5;
    logic [7:0]  icw2;
    logic [2:0]  level;
    logic        dve;
    logic [2:0]  exp_en;   // bit p-1 = enable during pulse p
    logic [23:0] exp_dat;  // byte p at [8*(p-1) +: 8]
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  task automatic set_cfg(input logic mode, input logic adi, input logic [2:0] a7_5,
                         input logic [7:0] icw2, input logic [2:0] level, input logic dve);
    u8086_or_mcs80_config               = mode;
    call_address_interval_4_or_8_config = adi;
    interrupt_vector_address            = a7_5;
    interrupt_vector_address_high       = icw2;
    acknowledge_level                   = level;
    drive_vector_enable                 = dve;
  endtask

  initial begin
    // mode adi a7_5 icw2 level dve | en(p3p2p1) bytes {p3,p2,p1}
    vecs[0] = '{1'b1, 1'b0, 3'b000, 8'h40, 3'd3, 1'b1, 3'b010, {8'h00, 8'h43, 8'h00}};
    vecs[1] = '{1'b0, 1'b1, 3'b101, 8'h12, 3'd6, 1'b1, 3'b111, {8'h12, 8'hB8, 8'hCD}};
    vecs[2] = '{1'b0, 1'b0, 3'b110, 8'h34, 3'd5, 1'b1, 3'b111, {8'h34, 8'hE8, 8'hCD}};
    vecs[3] = '{1'b0, 1'b1, 3'b000, 8'h55, 3'd2, 1'b0, 3'b001, {8'h00, 8'h00, 8'hCD}};
    vecs[4] = '{1'b1, 1'b0, 3'b111, 8'hF8, 3'd7, 1'b0, 3'b000, {8'h00, 8'h00, 8'h00}};
    vecs[5] = '{1'b1, 1'b1, 3'b010, 8'h4F, 3'd1, 1'b1, 3'b010, {8'h00, 8'h49, 8'h00}};

    reset_n = 1'b0;
    interrupt_acknowledge_n = 1'b1;
    initialization_write = 1'b0;
    set_cfg(1'b0, 1'b0, 3'b000, 8'h00, 3'd0, 1'b1);
    tick();
    tick();
    chk1("reset_latch", latch_in_service, 1'b0);
    chk1("reset_en", data_bus_out_enable, 1'b0);
    chk8("reset_dat", data_bus_out, 8'h00);
    chk1("reset_end", end_of_acknowledge_sequence, 1'b0);
    reset_n = 1'b1;
    tick();
    tick();

    // Table-driven full sequences; config is scrambled after the first fall
    // to confirm the driver works from its snapshot.
    for (int v = 0; v < 6; v++) begin
      int n;
      set_cfg(vecs[v].mode, vecs[v].adi, vecs[v].a7_5, vecs[v].icw2, vecs[v].level, vecs[v].dve);
      n = vecs[v].mode ? 2 : 3;
      for (int p = 1; p <= n; p++) begin
        logic       e;
        logic [7:0] d;
        e = vecs[v].exp_en[p-1];
        d = vecs[v].exp_dat[8*(p-1) +: 8];
        interrupt_acknowledge_n = 1'b0;
        tick();
        chk1($sformatf("v%0d_p%0d_latch", v, p), latch_in_service, p == 1);
        chk1($sformatf("v%0d_p%0d_en", v, p), data_bus_out_enable, e);
        chk8($sformatf("v%0d_p%0d_dat", v, p), data_bus_out, d);
        chk1($sformatf("v%0d_p%0d_end_low", v, p), end_of_acknowledge_sequence, 1'b0);
        if (p == 1)
          set_cfg(~vecs[v].mode, ~vecs[v].adi, ~vecs[v].a7_5, ~vecs[v].icw2, ~vecs[v].level, ~vecs[v].dve);
        tick();
        chk1($sformatf("v%0d_p%0d_latch_once", v, p), latch_in_service, 1'b0);
        chk8($sformatf("v%0d_p%0d_dat_hold", v, p), data_bus_out, d);
        interrupt_acknowledge_n = 1'b1;
        tick();
        chk1($sformatf("v%0d_p%0d_en_off", v, p), data_bus_out_enable, 1'b0);
        chk8($sformatf("v%0d_p%0d_dat_off", v, p), data_bus_out, 8'h00);
        chk1($sformatf("v%0d_p%0d_end", v, p), end_of_acknowledge_sequence, p == n);
        tick();
        chk1($sformatf("v%0d_p%0d_end_once", v, p), end_of_acknowledge_sequence, 1'b0);
      end
    end

    // Abort in WAIT2, then a new fall must restart at PULSE1.
    set_cfg(1'b0, 1'b1, 3'b101, 8'h12, 3'd6, 1'b1);
    interrupt_acknowledge_n = 1'b0;
    tick();
    chk8("abort_p1_dat", data_bus_out, 8'hCD);
    interrupt_acknowledge_n = 1'b1;
    tick();
    initialization_write = 1'b1;
    tick();
    initialization_write = 1'b0;
    chk1("abort_en", data_bus_out_enable, 1'b0);
    chk1("abort_end", end_of_acknowledge_sequence, 1'b0);
    tick();
    chk1("abort_end_after", end_of_acknowledge_sequence, 1'b0);
    interrupt_acknowledge_n = 1'b0;
    tick();
    chk1("restart_latch", latch_in_service, 1'b1);
    chk8("restart_dat", data_bus_out, 8'hCD);
    interrupt_acknowledge_n = 1'b1;
    tick();
    // Abort coincident with a fall in WAIT2: abort wins.
    interrupt_acknowledge_n = 1'b0;
    initialization_write = 1'b1;
    tick();
    initialization_write = 1'b0;
    chk1("abort_vs_fall_en", data_bus_out_enable, 1'b0);
    chk8("abort_vs_fall_dat", data_bus_out, 8'h00);
    tick();
    chk1("abort_vs_fall_idle_en", data_bus_out_enable, 1'b0);
    chk1("abort_vs_fall_latch", latch_in_service, 1'b0);
    interrupt_acknowledge_n = 1'b1;
    tick();

    // Reset released with INTA# low must not look like a fall.
    set_cfg(1'b1, 1'b0, 3'b000, 8'h40, 3'd3, 1'b1);
    reset_n = 1'b0;
    interrupt_acknowledge_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk1("rst_low_latch_a", latch_in_service, 1'b0);
    tick();
    chk1("rst_low_latch_b", latch_in_service, 1'b0);
    chk1("rst_low_en", data_bus_out_enable, 1'b0);
    interrupt_acknowledge_n = 1'b1;
    tick();
    chk1("rst_low_latch_c", latch_in_service, 1'b0);
    interrupt_acknowledge_n = 1'b0;
    tick();
    chk1("rst_seq_latch", latch_in_service, 1'b1);
    chk1("rst_seq_p1_en", data_bus_out_enable, 1'b0);
    tick();
    chk1("rst_seq_latch_once", latch_in_service, 1'b0);
    interrupt_acknowledge_n = 1'b1;
    tick();
    interrupt_acknowledge_n = 1'b0;
    tick();
    chk1("rst_seq_p2_en", data_bus_out_enable, 1'b1);
    chk8("rst_seq_p2_dat", data_bus_out, 8'h43);
    // Asynchronous reset mid-PULSE2 releases the bus without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk1("async_rst_en", data_bus_out_enable, 1'b0);
    chk8("async_rst_dat", data_bus_out, 8'h00);
    chk1("async_rst_end", end_of_acknowledge_sequence, 1'b0);
    tick();
    reset_n = 1'b1;
    interrupt_acknowledge_n = 1'b1;
    tick();
    tick();
    chk1("post_rst_end", end_of_acknowledge_sequence, 1'b0);
    chk1("post_rst_en", data_bus_out_enable, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
